// File: rtl/optical_arb_pkg.sv
// Shared types and helpers for the optical-port arbitration blocks.
package optical_arb_pkg;

  localparam int unsigned P_CHANNEL_NUM_DEF = 8;
  localparam int unsigned P_ONEHOT_MAX      = 64;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } arb_state_e;

  function automatic logic [5:0] onehot2idx(input logic [P_ONEHOT_MAX-1:0] oh);
    logic [5:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < P_ONEHOT_MAX; i++) begin
      if (oh[i]) idx |= 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first eligible bit at or after the one-hot pointer, wrapping.
module rr_pick #(
  parameter int P_N = 8
) (
  input  logic [P_N-1:0] eligible,
  input  logic [P_N-1:0] pointer_onehot,
  output logic [P_N-1:0] grant_onehot,
  output logic           any
);

  logic [2*P_N-1:0] dbl;
  logic [2*P_N-1:0] diff;
  logic [2*P_N-1:0] sel;

  // Subtracting the pointer from the doubled vector isolates the first set bit at/after it.
  assign dbl          = {eligible, eligible};
  assign diff         = dbl - {{P_N{1'b0}}, pointer_onehot};
  assign sel          = dbl & ~diff;
  assign grant_onehot = sel[P_N-1:0] | sel[2*P_N-1:P_N];
  assign any          = |eligible;

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking: holder keeps the grant until release, mask drop or hold timeout.
module rr_lock_arbiter
  import optical_arb_pkg::*;
#(
  parameter int P_CHANNEL_NUM = P_CHANNEL_NUM_DEF,
  parameter int P_IDX_W       = 3,
  parameter int P_MAX_HOLD    = 64,
  parameter int P_HOLD_W      = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [P_CHANNEL_NUM-1:0] i_req,
  input  logic [P_CHANNEL_NUM-1:0] i_last,
  input  logic [P_CHANNEL_NUM-1:0] i_mask,
  input  logic                     i_reset_priority,
  output logic [P_CHANNEL_NUM-1:0] o_grant,
  output logic [P_IDX_W-1:0]       o_grant_idx,
  output logic                     o_grant_valid,
  output logic                     o_timeout
);

  arb_state_e               state;
  logic [P_CHANNEL_NUM-1:0] ptr;
  logic [P_HOLD_W-1:0]      hold_cnt;

  logic [P_CHANNEL_NUM-1:0] eligible;
  logic [P_CHANNEL_NUM-1:0] ptr_rot;
  logic [P_CHANNEL_NUM-1:0] ptr_eff;
  logic [P_CHANNEL_NUM-1:0] pick_elig;
  logic [P_CHANNEL_NUM-1:0] pick_grant;
  logic [P_IDX_W-1:0]       pick_idx;
  logic                     pick_any;
  logic                     early_rel;
  logic                     tmo_hit;
  logic                     release_ev;

  always_comb begin
    eligible   = i_req & i_mask;
    early_rel  = (|(i_last & i_req & o_grant)) | ~(|(i_req & o_grant)) | ~(|(i_mask & o_grant));
    tmo_hit    = (P_MAX_HOLD != 0) && (hold_cnt == P_HOLD_W'(P_MAX_HOLD));
    release_ev = (state == ST_HOLD) && (early_rel || tmo_hit);
    ptr_rot    = {o_grant[P_CHANNEL_NUM-2:0], o_grant[P_CHANNEL_NUM-1]};
    // Pointer moves this cycle on release or priority reset; the pick must already see the new value.
    if (i_reset_priority)  ptr_eff = P_CHANNEL_NUM'(1);
    else if (release_ev)   ptr_eff = ptr_rot;
    else                   ptr_eff = ptr;
    pick_elig  = eligible & ~(release_ev ? o_grant : '0);
    pick_idx   = P_IDX_W'(onehot2idx(P_ONEHOT_MAX'(pick_grant)));
  end

  rr_pick #(
    .P_N (P_CHANNEL_NUM)
  ) u_pick (
    .eligible       (pick_elig),
    .pointer_onehot (ptr_eff),
    .grant_onehot   (pick_grant),
    .any            (pick_any)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      ptr           <= P_CHANNEL_NUM'(1);
      hold_cnt      <= '0;
      o_grant       <= '0;
      o_grant_idx   <= '0;
      o_grant_valid <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      if (i_reset_priority || release_ev) ptr <= ptr_eff;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state         <= ST_HOLD;
            o_grant       <= pick_grant;
            o_grant_idx   <= pick_idx;
            o_grant_valid <= 1'b1;
            hold_cnt      <= P_HOLD_W'(1);
          end
        end
        ST_HOLD: begin
          if (release_ev) begin
            o_timeout <= tmo_hit & ~early_rel;
            if (pick_any) begin
              o_grant       <= pick_grant;
              o_grant_idx   <= pick_idx;
              o_grant_valid <= 1'b1;
              hold_cnt      <= P_HOLD_W'(1);
            end else begin
              state         <= ST_IDLE;
              o_grant       <= '0;
              o_grant_idx   <= '0;
              o_grant_valid <= 1'b0;
              hold_cnt      <= '0;
            end
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + P_HOLD_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed and randomized checks of rr_lock_arbiter against a channel-number reference model.
module tb_rr_lock_arbiter;

  localparam int N    = 8;
  localparam int IW   = 3;
  localparam int MAXH = 4;
  localparam int HW   = 7;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, last, mask;
  logic         rp;
  logic [N-1:0] o_grant;
  logic [IW-1:0] o_grant_idx;
  logic         o_grant_valid;
  logic         o_timeout;

  int checks   = 0;
  int failures = 0;

  // reference model state: holder channel (-1 = none), pointer channel, hold count
  int m_holder = -1;
  int m_ptr    = 0;
  int m_cnt    = 0;
  bit m_tmo    = 1'b0;

  rr_lock_arbiter #(
    .P_CHANNEL_NUM (N),
    .P_IDX_W       (IW),
    .P_MAX_HOLD    (MAXH),
    .P_HOLD_W      (HW)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_req            (req),
    .i_last           (last),
    .i_mask           (mask),
    .i_reset_priority (rp),
    .o_grant          (o_grant),
    .o_grant_idx      (o_grant_idx),
    .o_grant_valid    (o_grant_valid),
    .o_timeout        (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int find_winner(input int start, input int excl,
                                     input logic [N-1:0] r, input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (c != excl && r[c] && m[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_holder = -1; m_ptr = 0; m_cnt = 0; m_tmo = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_holder >= 0) begin
        bit early, tmo;
        int win;
        early = (last[m_holder] && req[m_holder]) || !req[m_holder] || !mask[m_holder];
        tmo   = (MAXH != 0) && (m_cnt == MAXH);
        if (early || tmo) begin
          m_ptr    = rp ? 0 : (m_holder + 1) % N;
          win      = find_winner(m_ptr, m_holder, req, mask);
          m_tmo    = tmo && !early;
          m_holder = win;
          m_cnt    = (win >= 0) ? 1 : 0;
        end else begin
          m_cnt++;
          if (rp) m_ptr = 0;
        end
      end else begin
        int win;
        if (rp) m_ptr = 0;
        win = find_winner(m_ptr, -1, req, mask);
        if (win >= 0) begin
          m_holder = win;
          m_cnt    = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      logic [N-1:0] eg;
      eg = (m_holder >= 0) ? N'(1 << m_holder) : '0;
      chk("model_grant", o_grant, eg);
      chk("model_idx",   o_grant_idx, (m_holder >= 0) ? m_holder : 0);
      chk("model_valid", o_grant_valid, (m_holder >= 0) ? 1 : 0);
      chk("model_tmo",   o_timeout, m_tmo);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; last = '0; mask = '1; rp = 1'b0;
    @(negedge clk);
    chk("rst_grant", o_grant, 0);
    chk("rst_valid", o_grant_valid, 0);
    chk("rst_idx",   o_grant_idx, 0);
    chk("rst_tmo",   o_timeout, 0);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // idle with no requests; priority reset must not disturb outputs
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rp = i[0];
      step();
      chk("idle_valid", o_grant_valid, 0);
      chk("idle_grant", o_grant, 0);
    end
    rp = 1'b0;

    // 0x81: ch0 first, then zero-bubble hand-off to ch7
    do_reset();
    req = 8'h81;
    step(); chk("p81_g0", o_grant, 8'h01); chk("p81_i0", o_grant_idx, 0);
    last = 8'h01;
    step(); chk("p81_g7", o_grant, 8'h80); chk("p81_i7", o_grant_idx, 7); chk("p81_v", o_grant_valid, 1);
    last = '0; req = '0;
    step(); chk("p81_drop", o_grant_valid, 0);

    // all requesting, each holder releases on its third cycle
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      for (int j = 0; j < 3; j++) begin
        logic [N-1:0] e;
        e = N'(1 << (k % N));
        step();
        chk("rr_seq", o_grant, e);
        last = (j == 2) ? e : '0;
      end
    end
    last = '0;

    // timeout: ch1 holds exactly MAXH cycles, then ch2
    do_reset();
    req = 8'h06;
    for (int j = 0; j < MAXH; j++) begin
      step(); chk("tmo_hold", o_grant, 8'h02); chk("tmo_low", o_timeout, 0);
    end
    step(); chk("tmo_next", o_grant, 8'h04); chk("tmo_pulse", o_timeout, 1);
    step(); chk("tmo_pulse_end", o_timeout, 0);

    // mask removal moves grant without timeout
    do_reset();
    req = 8'h08;
    step(); chk("mask_g3", o_grant, 8'h08);
    req = 8'h18; mask = 8'hF7;
    step(); chk("mask_g4", o_grant, 8'h10); chk("mask_tmo", o_timeout, 0);
    mask = '1;

    // ch5 re-wins after idle cycle, then priority reset + release picks ch0
    do_reset();
    req = 8'h20;
    step(); chk("rp_g5", o_grant, 8'h20);
    last = 8'h20;
    step(); chk("rp_gap", o_grant, 8'h00);
    last = '0;
    step(); chk("rp_rewin", o_grant, 8'h20);
    req = 8'h21; last = 8'h20; rp = 1'b1;
    step(); chk("rp_g0", o_grant, 8'h01);
    last = '0; rp = 1'b0;

    // asynchronous reset mid-hold clears outputs immediately
    do_reset();
    req = 8'h01;
    step(); chk("ar_hold", o_grant, 8'h01);
    #2 rst = 1'b1;
    #1 chk("ar_grant", o_grant, 0); chk("ar_valid", o_grant_valid, 0); chk("ar_idx", o_grant_idx, 0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      req  = N'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      last = N'($urandom & $urandom);
      rp   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
